// File: rtl/stage_pkg.sv
// Shared types for the stage-block streamer: block record, stat bit positions, FSM states.
package stage_pkg;

  localparam int unsigned POS_W    = 16;
  localparam int unsigned STAT_TOP = 0;
  localparam int unsigned STAT_END = 1;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] left;
    logic [POS_W-1:0] right;
    logic [POS_W-1:0] height;
    logic [POS_W-1:0] stat;
  } block_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_PLAY    = 2'd2,
    ST_END     = 2'd3
  } state_t;

  // Split a raw ROM word {left,right,height,stat} into a valid block, shifted by ofs.
  function automatic block_t unpack_rec(input logic [4*POS_W-1:0] rec,
                                        input logic [POS_W-1:0]   ofs);
    block_t b;
    b.valid  = 1'b1;
    b.left   = rec[4*POS_W-1 -: POS_W] + ofs;
    b.right  = rec[3*POS_W-1 -: POS_W] + ofs;
    b.height = rec[2*POS_W-1 -: POS_W];
    b.stat   = rec[POS_W-1:0];
    return b;
  endfunction

endpackage

// File: rtl/stage_fetch.sv
// Stage ROM fetcher: address counter, one-cycle data capture and a single pending record.
// STAGE_LOOP_EN: address wraps to 0 and rewind adds the marker offset; otherwise it saturates.
module stage_fetch
  import stage_pkg::*;
#(
  parameter int unsigned STG_DEPTH = 64
) (
  input  logic                         i_clk_pix,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_consume,
  input  logic                         i_rewind,
  input  logic [POS_W-1:0]             i_rewind_ofs,
  output logic [$clog2(STG_DEPTH)-1:0] o_rom_addr,
  input  logic [4*POS_W-1:0]           i_rom_data,
  output block_t                       o_pend,
  output logic                         o_dry_c
);

  localparam int unsigned ADDR_W = $clog2(STG_DEPTH);

  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              done_q;
  logic [POS_W-1:0]  ofs_q;
  block_t            pend_q;
  logic              req_c;

  // A new address goes out only when the pending slot is free by the next edge.
  assign req_c = i_en && !inflight_q && !done_q && (!pend_q.valid || i_consume);

  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      ofs_q      <= '0;
      pend_q     <= '0;
    end else begin
      inflight_q <= req_c;
      if (i_rewind) begin
        addr_q <= '0;
        done_q <= 1'b0;
        ofs_q  <= ofs_q + i_rewind_ofs;
      end else if (req_c) begin
        if (addr_q == ADDR_W'(STG_DEPTH - 1)) begin
`ifdef STAGE_LOOP_EN
          addr_q <= '0;
`else
          done_q <= 1'b1;
`endif
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      if (inflight_q) begin
        pend_q <= unpack_rec(i_rom_data, ofs_q);
      end else if (i_consume) begin
        pend_q.valid <= 1'b0;
      end
    end
  end

  assign o_rom_addr = addr_q;
  assign o_pend     = pend_q;
  assign o_dry_c    = done_q && !inflight_q && !pend_q.valid;

endmodule

// File: rtl/stage_window.sv
// Stage-block window: circular buffer of visible blocks, pixel hit test, floor/ceiling query.
// STAGE_LOOP_EN: after the end marker drains, the stage replays shifted past the marker.
module stage_window
  import stage_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned STG_DEPTH = 64,
  parameter int unsigned H_RES     = 800,
  parameter int unsigned V_RES     = 600,
  parameter int unsigned LOOKAHEAD = 64
) (
  input  logic                          i_clk_pix,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [POS_W-1:0]              i_map_x,
  input  logic signed [POS_W-1:0]       i_sx,
  input  logic signed [POS_W-1:0]       i_sy,
  input  logic [POS_W-1:0]              i_foot_l,
  input  logic [POS_W-1:0]              i_foot_r,
  output logic [$clog2(STG_DEPTH)-1:0]  o_rom_addr,
  input  logic [4*POS_W-1:0]            i_rom_data,
  output logic                          o_ready,
  output logic                          o_drawing,
  output logic [POS_W-1:0]              o_floor,
  output logic [POS_W-1:0]              o_ceil,
  output logic [$clog2(BUF_DEPTH):0]    o_count,
  output logic                          o_stage_end,
  output logic                          o_overflow
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_t           state_q, state_d;
  block_t           win_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             ready_q, drawing_q, stage_end_q, overflow_q;
  logic [POS_W-1:0] floor_q, ceil_q;

  block_t           pend;
  logic             fetch_dry_c;
  logic             full_c, empty_c, in_range_c, pop_ok_c, end_rec_c;
  logic [POS_W-1:0] limit_c;
  logic             push_c, pop_c, fetch_en_c, ovf_set_c, rewind_c;

  stage_fetch #(
    .STG_DEPTH (STG_DEPTH)
  ) u_fetch (
    .i_clk_pix    (i_clk_pix),
    .i_rst        (i_rst),
    .i_en         (fetch_en_c),
    .i_consume    (push_c),
    .i_rewind     (rewind_c),
    .i_rewind_ofs (win_q[head_q].right),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_pend       (pend),
    .o_dry_c      (fetch_dry_c)
  );

  assign full_c     = (count_q == CNT_W'(BUF_DEPTH));
  assign empty_c    = (count_q == '0);
  assign limit_c    = i_map_x + POS_W'(H_RES + LOOKAHEAD);
  assign in_range_c = (pend.left <= limit_c);
  assign pop_ok_c   = !empty_c && (win_q[head_q].right < i_map_x);
  assign end_rec_c  = pend.stat[STAT_END];

  // State register
  always_ff @(posedge i_clk_pix) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        if (push_c && end_rec_c) state_d = ST_END;
        else if (full_c || (pend.valid && !in_range_c) || fetch_dry_c) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (push_c && end_rec_c) state_d = ST_END;
      end
      ST_END: begin
`ifdef STAGE_LOOP_EN
        if (count_q == CNT_W'(1)) state_d = ST_PLAY;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: window push/pop strobes and fetch control
  always_comb begin
    push_c     = 1'b0;
    pop_c      = 1'b0;
    fetch_en_c = 1'b0;
    ovf_set_c  = 1'b0;
    rewind_c   = 1'b0;
    case (state_q)
      ST_PRELOAD, ST_PLAY: begin
        push_c     = pend.valid && !full_c && in_range_c;
        pop_c      = (state_q == ST_PLAY) && pop_ok_c;
        fetch_en_c = !(push_c && end_rec_c);
        ovf_set_c  = pend.valid && full_c && in_range_c;
      end
      ST_END: begin
        pop_c = pop_ok_c;
`ifdef STAGE_LOOP_EN
        rewind_c = (count_q == CNT_W'(1));
`endif
      end
      default: ;
    endcase
  end

  // Window buffer and status registers
  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) win_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      stage_end_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push_c) begin
        win_q[tail_q] <= pend;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop_c) begin
        win_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
      ready_q     <= (state_d == ST_PLAY) || (state_d == ST_END);
      stage_end_q <= (state_q == ST_END) && (count_q == CNT_W'(1));
      if (ovf_set_c) overflow_q <= 1'b1;
    end
  end

  // Pixel hit test and footprint floor/ceiling over every valid entry
  logic [POS_W-1:0] px_c, sy_c;
  logic             hit_c;
  logic [POS_W-1:0] floor_c, ceil_c;

  assign px_c = i_map_x + $unsigned(i_sx);
  assign sy_c = $unsigned(i_sy);

  always_comb begin
    hit_c   = 1'b0;
    floor_c = '0;
    ceil_c  = POS_W'(V_RES);
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      if (win_q[i].valid) begin
        if (win_q[i].left <= px_c && px_c <= win_q[i].right) begin
          if (win_q[i].stat[STAT_TOP]) begin
            if (sy_c <= win_q[i].height) hit_c = 1'b1;
          end else begin
            if (sy_c >= POS_W'(V_RES) - win_q[i].height) hit_c = 1'b1;
          end
        end
        if (win_q[i].left <= i_foot_r && win_q[i].right >= i_foot_l) begin
          if (win_q[i].stat[STAT_TOP]) begin
            if (win_q[i].height < ceil_c) ceil_c = win_q[i].height;
          end else begin
            if (win_q[i].height > floor_c) floor_c = win_q[i].height;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      drawing_q <= 1'b0;
      floor_q   <= '0;
      ceil_q    <= POS_W'(V_RES);
    end else begin
      drawing_q <= hit_c;
      floor_q   <= floor_c;
      ceil_q    <= ceil_c;
    end
  end

  assign o_ready     = ready_q;
  assign o_drawing   = drawing_q;
  assign o_floor     = floor_q;
  assign o_ceil      = ceil_q;
  assign o_count     = count_q;
  assign o_stage_end = stage_end_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_stage_window.sv
// Directed bench for stage_window: preload, scroll, overflow, hit test, floor/ceil, end, reset.
module tb_stage_window;

  localparam int unsigned PW   = 16;
  localparam int unsigned BUFD = 4;
  localparam int unsigned STGD = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [PW-1:0]        map_x = '0;
  logic signed [PW-1:0] sx = '0;
  logic signed [PW-1:0] sy = '0;
  logic [PW-1:0]        foot_l = '0;
  logic [PW-1:0]        foot_r = '0;
  logic [3:0]           rom_addr;
  logic [4*PW-1:0]      rom_data = '0;
  logic                 ready, drawing, stage_end, overflow;
  logic [PW-1:0]        floor_v, ceil_v;
  logic [2:0]           count;

  logic [4*PW-1:0]      rom [STGD];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  stage_window #(
    .BUF_DEPTH (BUFD),
    .STG_DEPTH (STGD),
    .H_RES     (800),
    .V_RES     (600),
    .LOOKAHEAD (64)
  ) dut (
    .i_clk_pix   (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_map_x     (map_x),
    .i_sx        (sx),
    .i_sy        (sy),
    .i_foot_l    (foot_l),
    .i_foot_r    (foot_r),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_ready     (ready),
    .o_drawing   (drawing),
    .o_floor     (floor_v),
    .o_ceil      (ceil_v),
    .o_count     (count),
    .o_stage_end (stage_end),
    .o_overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4*PW-1:0] rec(input int l, input int r, input int h, input int s);
    return {16'(l), 16'(r), 16'(h), 16'(s)};
  endfunction

  task automatic fill_far();
    for (int i = 0; i < STGD; i++) rom[i] = rec(16'hF000, 16'hF100, 10, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic go_and_wait(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 64 && !ready; i++) tick();
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp);
    sx = 16'(x);
    sy = 16'(y);
    tick();
    check(tag, 32'(drawing), 32'(exp));
  endtask

  task automatic foot(input string tag, input int l, input int r, input int fl, input int ce);
    foot_l = 16'(l);
    foot_r = 16'(r);
    tick();
    check({tag, "_floor"}, 32'(floor_v), 32'(fl));
    check({tag, "_ceil"}, 32'(ceil_v), 32'(ce));
  endtask

  initial begin
    fill_far();
    do_reset();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_floor", 32'(floor_v), 32'd0);
    check("rst_ceil", 32'(ceil_v), 32'd600);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_end", 32'(stage_end), 32'd0);
    check("rst_draw", 32'(drawing), 32'd0);

    // Preload stops at the over-range block at 900, which stays pending
    fill_far();
    rom[0] = rec(0, 250, 50, 0);
    rom[1] = rec(300, 500, 80, 0);
    rom[2] = rec(900, 1000, 60, 0);
    do_reset();
    map_x = 16'd0;
    tick(3);
    check("idle_ready", 32'(ready), 32'd0);
    go_and_wait("pre_ready");
    tick(4);
    check("pre_count", 32'(count), 32'd2);
    check("pre_addr", 32'(rom_addr), 32'd3);
    pix("pre_pend_not_in_win", 950, 560, 0);

    // Scroll to 400: pop block 0 and push 900 together, count holds at 2
    map_x = 16'd400;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("scroll_count", 32'(count), 32'd2);
    end
    pix("scroll_new_blk", 550, 560, 1);
    pix("scroll_popped_blk", -250, 599, 0);

    // Reset in the middle of PLAY
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_addr", 32'(rom_addr), 32'd0);
    check("midrst_ceil", 32'(ceil_v), 32'd600);
    tick(4);
    check("midrst_idle", 32'(ready), 32'd0);

    // Hit test and floor/ceiling over bottom/top/bottom blocks
    fill_far();
    rom[0] = rec(100, 200, 50, 0);
    rom[1] = rec(100, 200, 40, 1);
    rom[2] = rec(210, 260, 80, 0);
    map_x = 16'd0;
    do_reset();
    go_and_wait("hit_ready");
    tick(2);
    check("hit_count", 32'(count), 32'd3);
    pix("bot_edge_in", 150, 550, 1);
    pix("bot_edge_out", 150, 549, 0);
    pix("top_edge_in", 150, 40, 1);
    pix("top_edge_out", 150, 41, 0);
    pix("right_edge_in", 200, 550, 1);
    pix("right_edge_out", 201, 550, 0);
    foot("foot_two_bot", 180, 220, 80, 40);
    foot("foot_gap", 300, 350, 0, 600);
    foot("foot_one_bot", 100, 150, 50, 40);
    foot("foot_touch_right", 260, 300, 80, 600);

    // Six near blocks into a 4-deep window: overflow, no overwrite
    fill_far();
    for (int i = 0; i < 6; i++) rom[i] = rec(10 * i, 10 * i + 5, 5, 0);
    do_reset();
    go_and_wait("ovf_ready");
    tick(6);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    pix("ovf_blk0_kept", 2, 599, 1);
    pix("ovf_blk3_kept", 32, 599, 1);
    pix("ovf_blk4_absent", 42, 599, 0);

    // End marker: no fetch after it, stage_end once only the marker remains
    fill_far();
    rom[0] = rec(0, 100, 10, 0);
    rom[1] = rec(200, 300, 10, 2);
    map_x = 16'd0;
    do_reset();
    go_and_wait("end_ready");
    tick(2);
    check("end_count", 32'(count), 32'd2);
    check("end_addr", 32'(rom_addr), 32'd2);
    check("end_not_yet", 32'(stage_end), 32'd0);
    map_x = 16'd150;
    tick(3);
    check("end_drained", 32'(count), 32'd1);
    check("end_flag", 32'(stage_end), 32'd1);
    check("end_ready_hold", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
